// File: rtl/vslc_spi_mem_responder.sv
// vslc_spi_mem_responder: SPI mode-0 target emulating a 25xx serial memory.
// Supports READ (0x03), WRITE (0x02) and RDSR (0x05). Other opcodes are ignored.
// SCK, CS_N and MOSI are oversampled in the clk domain. No logic is clocked by SCK.
// Ports:
//   clk, rst_n           system clock (>= 8x SCK) and async active-low reset
//   sck, cs_n, mosi      SPI inputs from the initiator
//   miso, miso_oe        responder data and its drive enable
//   mem_addr             memory address
//   mem_re               read strobe
//   mem_rdata            read data, valid one clk after mem_re
//   mem_we, mem_wdata    write strobe and write data
//   txn_done             pulse at cs_n deassert after at least one bit
module vslc_spi_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              txn_done
);

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA_RD, S_DATA_WR, S_STATUS, S_IGNORE
  } state_e;

  // Synchronizers reset to 0, including cs_n. A reset taken while cs_n is low
  // therefore never produces a false cs_n fall. The transfer in progress stays
  // dead until the initiator starts a new one.
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_in_q, shift_in_d;
  logic [7:0]        shift_out_q, shift_out_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic              is_rd_q, is_rd_d;
  logic              any_bit_q, any_bit_d;
  logic              rd_wait_q, rd_wait_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              txn_done_q, txn_done_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 8'd0;
      addr_hi_q   <= 8'd0;
      is_rd_q     <= 1'b0;
      any_bit_q   <= 1'b0;
      rd_wait_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      txn_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_hi_q   <= addr_hi_d;
      is_rd_q     <= is_rd_d;
      any_bit_q   <= any_bit_d;
      rd_wait_q   <= rd_wait_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      txn_done_q  <= txn_done_d;
    end
  end

  logic [7:0] byte_in;
  logic       byte_done;

  assign byte_in   = {shift_in_q[6:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_hi_d   = addr_hi_q;
    is_rd_d     = is_rd_q;
    any_bit_d   = any_bit_q;
    rd_wait_d   = mem_re_q;
    miso_d      = miso_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    txn_done_d  = 1'b0;

    // The address advances one cycle after a write strobe.
    // This keeps mem_addr stable for the whole strobe cycle.
    if (mem_we_q) mem_addr_d = mem_addr_q + ADDR_W'(1);

    if (cs_rise) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 3'd0;
      txn_done_d = any_bit_q;
      any_bit_d  = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (cs_fall) begin
        state_d   = S_CMD;
        bit_cnt_d = 3'd0;
        any_bit_d = 1'b0;
      end
    end else begin
      if (sck_rise) begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        shift_in_d = byte_in;
        any_bit_d  = 1'b1;
      end
      if (sck_fall && (state_q == S_DATA_RD || state_q == S_STATUS)) begin
        miso_d      = shift_out_q[7];
        shift_out_d = {shift_out_q[6:0], 1'b0};
      end
      if (byte_done) begin
        unique case (state_q)
          S_CMD: begin
            unique case (byte_in)
              CMD_READ:  begin state_d = S_ADDR_HI; is_rd_d = 1'b1; end
              CMD_WRITE: begin state_d = S_ADDR_HI; is_rd_d = 1'b0; end
              CMD_RDSR:  begin state_d = S_STATUS;  shift_out_d = 8'h00; end
              default:   state_d = S_IGNORE;
            endcase
          end
          S_ADDR_HI: begin
            addr_hi_d = byte_in;
            state_d   = S_ADDR_LO;
          end
          S_ADDR_LO: begin
            mem_addr_d = ADDR_W'({addr_hi_q, byte_in});
            if (is_rd_q) begin
              state_d  = S_DATA_RD;
              mem_re_d = 1'b1;
            end else begin
              state_d  = S_DATA_WR;
            end
          end
          S_DATA_RD: begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            mem_re_d   = 1'b1;
          end
          S_DATA_WR: begin
            mem_we_d    = 1'b1;
            mem_wdata_d = byte_in;
          end
          S_STATUS: shift_out_d = 8'h00;
          default: ;
        endcase
      end
      // Fetched byte lands in the shift register well before the next SCK fall.
      if (state_q == S_DATA_RD && rd_wait_q) shift_out_d = mem_rdata;
    end

    miso_oe_d = (state_d == S_DATA_RD) || (state_d == S_STATUS);
    if (!miso_oe_d) miso_d = 1'b0;
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign txn_done  = txn_done_q;

endmodule

// File: tb/tb_vslc_spi_mem_responder.sv
// Bench for vslc_spi_mem_responder.
// The bench acts as the SPI initiator and as a byte-wide memory.
// Expected values come from a reference memory image and address arithmetic.
module tb_vslc_spi_mem_responder;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned MEM_SZ = 1 << ADDR_W;
  localparam int unsigned HALF   = 80;

  logic              clk;
  logic              rst_n;
  logic              sck, cs_n, mosi;
  logic              miso, miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [7:0]        mem_rdata = 8'd0;
  logic [7:0]        mem_wdata;
  logic              txn_done;

  vslc_spi_mem_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .txn_done(txn_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] init_byte(input int unsigned a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Device memory and strobe monitor, sampled on the falling clk edge.
  logic [7:0]  dev_mem[MEM_SZ];
  bit          dev_valid[MEM_SZ];
  int unsigned rd_addrs[$];
  int unsigned wr_addrs[$];
  logic [7:0]  wr_data[$];
  int          txn_cnt  = 0;
  int          oe_cnt   = 0;
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (mem_re) begin
      mem_rdata <= dev_valid[mem_addr] ? dev_mem[mem_addr] : init_byte(32'(mem_addr));
      rd_addrs.push_back(32'(mem_addr));
    end
    if (mem_we) begin
      dev_mem[mem_addr]   <= mem_wdata;
      dev_valid[mem_addr] <= 1'b1;
      wr_addrs.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    if (miso_oe) oe_cnt <= oe_cnt + 1;
    if (txn_done) txn_cnt <= txn_cnt + 1;
  end

  logic [7:0] ref_mem[MEM_SZ];
  logic [7:0] tx_buf[8];
  logic [7:0] rx_buf[8];
  logic [7:0] oe_buf[8];

  // ---------------- initiator primitives ----------------
  task automatic spi_bit(input logic b, output logic r, output logic oe);
    mosi = b;
    #(HALF);
    r  = miso;
    oe = miso_oe;
    sck = 1'b1;
    #(HALF);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i], oe[i]);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    #(HALF);
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [7:0] rx, oe;
    cs_begin();
    spi_byte(8'h03, rx, oe);
    spi_byte(a[15:8], rx, oe);
    spi_byte(a[7:0], rx, oe);
    for (int i = 0; i < n; i++) spi_byte(8'($urandom), rx_buf[i], oe_buf[i]);
    cs_end();
  endtask

  task automatic do_write(input logic [15:0] a, input int n);
    logic [7:0] rx, oe;
    cs_begin();
    spi_byte(8'h02, rx, oe);
    spi_byte(a[15:8], rx, oe);
    spi_byte(a[7:0], rx, oe);
    for (int i = 0; i < n; i++) begin
      spi_byte(tx_buf[i], rx, oe);
      ref_mem[(32'(a) + i) % MEM_SZ] = tx_buf[i];
    end
    cs_end();
  endtask

  // Writes tx_buf[0..n-1] at a. Checks the strobes, then reads the data back.
  task automatic write_and_check(input logic [15:0] a, input int n, input string tag);
    int wb, tb0;
    int unsigned ea;
    wb  = wr_addrs.size();
    tb0 = txn_cnt;
    do_write(a, n);
    n_tests++;
    if (wr_addrs.size() - wb !== n) begin
      n_fail++;
      $display("FAIL %s write count: got %0d want %0d", tag, wr_addrs.size() - wb, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ea = (32'(a) + i) % MEM_SZ;
        n_tests++;
        if (wr_addrs[wb+i] !== ea || wr_data[wb+i] !== tx_buf[i]) begin
          n_fail++;
          $display("FAIL %s write %0d: got (%03h,%02h) want (%03h,%02h)", tag, i,
                   wr_addrs[wb+i], wr_data[wb+i], ea, tx_buf[i]);
        end
      end
    end
    n_tests++;
    if (txn_cnt - tb0 !== 1) begin
      n_fail++;
      $display("FAIL %s txn_done: got %0d want 1", tag, txn_cnt - tb0);
    end
    do_read(a, n);
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (rx_buf[i] !== ref_mem[(32'(a) + i) % MEM_SZ]) begin
        n_fail++;
        $display("FAIL %s readback %0d: got %02h want %02h", tag, i, rx_buf[i],
                 ref_mem[(32'(a) + i) % MEM_SZ]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    #30;
    n_tests++;
    if ({miso, miso_oe, mem_re, mem_we, txn_done} !== 5'b0 || mem_addr !== '0 || mem_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset outputs: got miso=%b oe=%b re=%b we=%b done=%b addr=%h wdata=%h want all 0",
               miso, miso_oe, mem_re, mem_we, txn_done, mem_addr, mem_wdata);
    end
    #10 rst_n = 1'b1;
    #200;
    n_tests++;
    if (txn_cnt !== 0 || oe_cnt !== 0 || rd_addrs.size() !== 0 || wr_addrs.size() !== 0) begin
      n_fail++;
      $display("FAIL post-reset idle: got txn=%0d oe=%0d rd=%0d wr=%0d want 0",
               txn_cnt, oe_cnt, rd_addrs.size(), wr_addrs.size());
    end
  endtask

  task automatic test_read_basic();
    int rb, tb0;
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h3C;
    do_write(16'h0005, 2);
    rb  = rd_addrs.size();
    tb0 = txn_cnt;
    do_read(16'h0005, 2);
    n_tests++;
    if (rx_buf[0] !== 8'hA5 || rx_buf[1] !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_basic data: got %02h %02h want a5 3c", rx_buf[0], rx_buf[1]);
    end
    n_tests++;
    if (rd_addrs.size() - rb !== 3) begin
      n_fail++;
      $display("FAIL read_basic re count: got %0d want 3", rd_addrs.size() - rb);
    end else begin
      n_tests++;
      if (rd_addrs[rb] !== 5 || rd_addrs[rb+1] !== 6 || rd_addrs[rb+2] !== 7) begin
        n_fail++;
        $display("FAIL read_basic re addrs: got %0h %0h %0h want 5 6 7",
                 rd_addrs[rb], rd_addrs[rb+1], rd_addrs[rb+2]);
      end
    end
    n_tests++;
    if (txn_cnt - tb0 !== 1) begin
      n_fail++;
      $display("FAIL read_basic txn_done: got %0d want 1", txn_cnt - tb0);
    end
  endtask

  task automatic test_read_random();
    logic [15:0] a;
    int n;
    for (int k = 0; k < 4; k++) begin
      a = 16'($urandom);
      n = 1 + int'($urandom_range(3));
      do_read(a, n);
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (rx_buf[i] !== ref_mem[(32'(a) + i) % MEM_SZ] || oe_buf[i] !== 8'hFF) begin
          n_fail++;
          $display("FAIL read_random a=%04h byte %0d: got %02h oe=%02h want %02h oe=ff", a, i,
                   rx_buf[i], oe_buf[i], ref_mem[(32'(a) + i) % MEM_SZ]);
        end
      end
    end
  endtask

  task automatic test_write_random();
    logic [15:0] a;
    int n;
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom);
      n = 1 + int'($urandom_range(3));
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      write_and_check(a, n, "write_random");
    end
  endtask

  task automatic test_write_wrap();
    tx_buf[0] = 8'hDE; tx_buf[1] = 8'hAD;
    write_and_check(16'h01FF, 2, "write_1ff");
    write_and_check(16'hFFFF, 2, "write_wrap");
  endtask

  task automatic test_status();
    logic [7:0] rx, oe;
    int n, rb, wb, tb0;
    rb = rd_addrs.size(); wb = wr_addrs.size(); tb0 = txn_cnt;
    n = 1 + int'($urandom_range(2));
    cs_begin();
    spi_byte(8'h05, rx, oe);
    n_tests++;
    if (oe !== 8'h00) begin
      n_fail++;
      $display("FAIL status cmd oe: got %02h want 00", oe);
    end
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), rx, oe);
      n_tests++;
      if (rx !== 8'h00 || oe !== 8'hFF) begin
        n_fail++;
        $display("FAIL status byte %0d: got %02h oe=%02h want 00 oe=ff", i, rx, oe);
      end
    end
    cs_end();
    n_tests++;
    if (rd_addrs.size() != rb || wr_addrs.size() != wb || txn_cnt - tb0 !== 1 || miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL status side effects: got rd=%0d wr=%0d txn=%0d oe=%b want 0 0 1 0",
               rd_addrs.size() - rb, wr_addrs.size() - wb, txn_cnt - tb0, miso_oe);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] cmd, rx, oe;
    int rb, wb, tb0, ob;
    for (int k = 0; k < 2; k++) begin
      do cmd = 8'($urandom); while (cmd == 8'h02 || cmd == 8'h03 || cmd == 8'h05);
      if (k == 0) cmd = 8'h9F;
      rb = rd_addrs.size(); wb = wr_addrs.size(); tb0 = txn_cnt; ob = oe_cnt;
      cs_begin();
      spi_byte(cmd, rx, oe);
      spi_byte(8'($urandom), rx, oe);
      spi_byte(8'($urandom), rx, oe);
      cs_end();
      n_tests++;
      if (oe_cnt != ob || rd_addrs.size() != rb || wr_addrs.size() != wb || txn_cnt - tb0 !== 1 || rx !== 8'h00) begin
        n_fail++;
        $display("FAIL ignore cmd=%02h: got oe=%0d rd=%0d wr=%0d txn=%0d rx=%02h want 0 0 0 1 00", cmd,
                 oe_cnt - ob, rd_addrs.size() - rb, wr_addrs.size() - wb, txn_cnt - tb0, rx);
      end
    end
  endtask

  task automatic test_partial_write();
    logic [7:0] rx, oe;
    logic r, o;
    int wb, tb0;
    wb = wr_addrs.size(); tb0 = txn_cnt;
    cs_begin();
    spi_byte(8'h02, rx, oe);
    spi_byte(8'h00, rx, oe);
    spi_byte(8'h10, rx, oe);
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom), r, o);
    cs_end();
    n_tests++;
    if (wr_addrs.size() != wb || txn_cnt - tb0 !== 1) begin
      n_fail++;
      $display("FAIL partial_write: got wr=%0d txn=%0d want 0 1", wr_addrs.size() - wb, txn_cnt - tb0);
    end
    do_read(16'h0010, 1);
    n_tests++;
    if (rx_buf[0] !== ref_mem[16]) begin
      n_fail++;
      $display("FAIL partial_write readback: got %02h want %02h", rx_buf[0], ref_mem[16]);
    end
  endtask

  task automatic test_no_bits();
    int tb0;
    tb0 = txn_cnt;
    cs_n = 1'b0;
    #(2*HALF);
    cs_n = 1'b1;
    #(2*HALF);
    n_tests++;
    if (txn_cnt != tb0) begin
      n_fail++;
      $display("FAIL no_bits txn_done: got %0d want 0", txn_cnt - tb0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, oe;
    logic r, o;
    int rb, wb, tb0, ob;
    cs_begin();
    spi_byte(8'h03, rx, oe);
    spi_byte(8'h01, rx, oe);
    spi_byte(8'h23, rx, oe);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r, o);
    n_tests++;
    if (o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid oe before reset: got %b want 1", o);
    end
    #40;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (miso_oe !== 1'b0 || miso !== 1'b0 || mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid immediate: got oe=%b miso=%b re=%b want 0 0 0", miso_oe, miso, mem_re);
    end
    #29;
    rst_n = 1'b1;
    #20;
    rb = rd_addrs.size(); wb = wr_addrs.size(); tb0 = txn_cnt; ob = oe_cnt;
    for (int i = 0; i < 16; i++) spi_bit(1'($urandom), r, o);
    cs_end();
    n_tests++;
    if (oe_cnt != ob || rd_addrs.size() != rb || wr_addrs.size() != wb || txn_cnt != tb0) begin
      n_fail++;
      $display("FAIL reset_mid dead: got oe=%0d rd=%0d wr=%0d txn=%0d want 0 0 0 0",
               oe_cnt - ob, rd_addrs.size() - rb, wr_addrs.size() - wb, txn_cnt - tb0);
    end
    do_read(16'h0123, 1);
    n_tests++;
    if (rx_buf[0] !== ref_mem[32'h123]) begin
      n_fail++;
      $display("FAIL reset_mid recover: got %02h want %02h", rx_buf[0], ref_mem[32'h123]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, a2;
    logic [7:0]  r1;
    int tb0;
    a1 = 16'($urandom); a2 = 16'($urandom);
    tb0 = txn_cnt;
    do_read(a1, 1);
    r1 = rx_buf[0];
    do_read(a2, 1);
    n_tests++;
    if (r1 !== ref_mem[32'(a1) % MEM_SZ] || rx_buf[0] !== ref_mem[32'(a2) % MEM_SZ] || txn_cnt - tb0 !== 2) begin
      n_fail++;
      $display("FAIL back_to_back: got %02h %02h txn=%0d want %02h %02h txn=2", r1, rx_buf[0],
               txn_cnt - tb0, ref_mem[32'(a1) % MEM_SZ], ref_mem[32'(a2) % MEM_SZ]);
    end
  endtask

  task automatic test_exclusive();
    n_tests++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL exclusive strobes: got %0d overlapping cycles want 0", both_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_SZ); i++) ref_mem[i] = init_byte(i);
    test_reset();
    test_read_basic();
    test_read_random();
    test_write_random();
    test_write_wrap();
    test_status();
    test_ignore();
    test_partial_write();
    test_no_bits();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
